// File: rtl/sdram_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_rd_arbiter_if
// Avalon-MM read-only port bundle. One instance is used for each requester
// link and one for the link to the SDRAM controller.
//   read          : read command, held until accepted
//   address       : byte address
//   waitrequest   : stall from the slave side
//   readdata      : response data
//   readdatavalid : one-cycle response strobe
// Modports:
//   master : the side that issues reads (requester, or the arbiter towards SDRAM)
//   slave  : the side that accepts reads (arbiter towards a requester)
// -----------------------------------------------------------------------------
interface sdram_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              read;
   logic [ADDR_W-1:0] address;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output read, address,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  read, address,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sdram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_rd_arbiter
// Shares one SDRAM controller read port between two Avalon-MM requesters
// (0: DNN accelerator fetch, 1: VGA framebuffer fetch). Round-robin grant,
// at most MAX_PEND reads outstanding at the controller, responses routed back
// in issue order through a FIFO of requester IDs.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   m0, m1     : requester links (slave modport)
//   s          : SDRAM controller link (master modport)
//   busy       : command in flight or reads outstanding
//   err_orphan : sticky, a response arrived with no outstanding read
// -----------------------------------------------------------------------------
module sdram_rd_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_PEND = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sdram_rd_arbiter_if.slave    m0,
   sdram_rd_arbiter_if.slave    m1,
   sdram_rd_arbiter_if.master   s,
   output logic                 busy,
   output logic                 err_orphan
);

   localparam int PTR_W = $clog2(MAX_PEND);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t              state_q;
   logic                s_read_q;
   logic [ADDR_W-1:0]   s_address_q;
   logic                grant_id_q;
   logic                last_grant_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic                id_fifo_q [MAX_PEND];
   logic [1:0]          rdv_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_orphan_q;

   logic can_grant;
   logic win0;
   logic win1;
   logic push;
   logic pop;
   logic orphan;
   logic fifo_empty;
   logic head_id;

   // A grant looks only at the count as registered this cycle, so a pop in
   // the same cycle frees a slot one cycle later. rst_n gates the grant so
   // both waitrequests read high while reset is held.
   assign can_grant = rst_n && (state_q == ST_IDLE) && (count_q < CNT_W'(MAX_PEND));

   // On a tie the requester that did not win last time gets the slot.
   assign win0 = can_grant && m0.read && (!m1.read || last_grant_q);
   assign win1 = can_grant && m1.read && (!m0.read || !last_grant_q);

   assign push       = (state_q == ST_ISSUE) && !s.waitrequest;
   assign fifo_empty = (count_q == '0);
   assign pop        = s.readdatavalid && !fifo_empty;
   assign orphan     = s.readdatavalid && fifo_empty;
   assign head_id    = id_fifo_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         s_read_q     <= 1'b0;
         s_address_q  <= '0;
         grant_id_q   <= 1'b0;
         last_grant_q <= 1'b1;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rdv_q        <= 2'b00;
         rdata_q      <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win0 || win1) begin
                  s_address_q  <= win1 ? m1.address : m0.address;
                  grant_id_q   <= win1;
                  last_grant_q <= win1;
                  s_read_q     <= 1'b1;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Command and address stay frozen until the controller takes it.
               if (!s.waitrequest) begin
                  s_read_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               s_read_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase

         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end

         rdv_q <= 2'b00;
         if (pop) begin
            rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
            rdv_q[head_id] <= 1'b1;
            rdata_q        <= s.readdata;
         end

         // Orphan data is dropped; only the sticky flag records it.
         if (orphan) begin
            err_orphan_q <= 1'b1;
         end

         count_q <= count_d;
      end
   end

   // ID storage needs no reset: the pointers and count define which entries
   // are live.
   always_ff @(posedge clk) begin
      if (push) begin
         id_fifo_q[wr_ptr_q] <= grant_id_q;
      end
   end

   assign m0.waitrequest   = !win0;
   assign m0.readdata      = rdata_q;
   assign m0.readdatavalid = rdv_q[0];
   assign m1.waitrequest   = !win1;
   assign m1.readdata      = rdata_q;
   assign m1.readdatavalid = rdv_q[1];

   assign s.read    = s_read_q;
   assign s.address = s_address_q;

   assign busy       = (state_q == ST_ISSUE) || (count_q != '0);
   assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_rd_arbiter
// Drives two requesters and an SDRAM controller emulation around
// sdram_rd_arbiter. A queue-level reference model, updated once per cycle,
// predicts every output; directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_sdram_rd_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
   sdram_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
   sdram_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

   logic          busy;
   logic          err_orphan;
   logic          m_read [2];
   logic [AW-1:0] m_addr [2];
   logic          s_wait;
   logic          s_rdv;
   logic [DW-1:0] s_rdata;

   assign m0_bus.read          = m_read[0];
   assign m0_bus.address       = m_addr[0];
   assign m1_bus.read          = m_read[1];
   assign m1_bus.address       = m_addr[1];
   assign s_bus.waitrequest    = s_wait;
   assign s_bus.readdata       = s_rdata;
   assign s_bus.readdatavalid  = s_rdv;

   sdram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0         (m0_bus),
      .m1         (m1_bus),
      .s          (s_bus),
      .busy       (busy),
      .err_orphan (err_orphan)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures < 60)
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (queue of outstanding IDs) -------------
   bit            md_issue;
   logic [AW-1:0] md_addr;
   int            md_id;
   int            md_last;
   int            md_pend[$];
   bit            md_vld [2];
   logic [DW-1:0] md_data;
   bit            md_err;
   int            glog[$];
   int            rlog[$];
   int            pushpop_cnt = 0;

   always @(negedge clk) begin : model_blk
      bit can, win0, win1, push, popv;
      bit nv [2];
      int id;
      if (!rst_n) begin
         chk("rst_s_read", s_bus.read, 0);
         chk("rst_s_address", s_bus.address, 0);
         chk("rst_m0_wait", m0_bus.waitrequest, 1);
         chk("rst_m1_wait", m1_bus.waitrequest, 1);
         chk("rst_m0_rdv", m0_bus.readdatavalid, 0);
         chk("rst_m1_rdv", m1_bus.readdatavalid, 0);
         chk("rst_m0_data", m0_bus.readdata, 0);
         chk("rst_m1_data", m1_bus.readdata, 0);
         chk("rst_busy", busy, 0);
         chk("rst_err", err_orphan, 0);
         md_issue = 0; md_addr = '0; md_id = 0; md_last = 1;
         md_pend.delete(); md_vld = '{0, 0}; md_data = '0; md_err = 0;
      end else begin
         can  = !md_issue && (md_pend.size() < MP);
         win0 = can && m_read[0] && (!m_read[1] || md_last == 1);
         win1 = can && m_read[1] && (!m_read[0] || md_last == 0);
         chk("s_read", s_bus.read, md_issue);
         chk("s_address", s_bus.address, md_addr);
         chk("m0_wait", m0_bus.waitrequest, !win0);
         chk("m1_wait", m1_bus.waitrequest, !win1);
         chk("m0_rdv", m0_bus.readdatavalid, md_vld[0]);
         chk("m1_rdv", m1_bus.readdatavalid, md_vld[1]);
         if (md_vld[0]) chk("m0_data", m0_bus.readdata, md_data);
         if (md_vld[1]) chk("m1_data", m1_bus.readdata, md_data);
         chk("busy", busy, md_issue || (md_pend.size() != 0));
         chk("err_orphan", err_orphan, md_err);

         if (!m0_bus.waitrequest) glog.push_back(0);
         if (!m1_bus.waitrequest) glog.push_back(1);
         if (m0_bus.readdatavalid) rlog.push_back(0);
         if (m1_bus.readdatavalid) rlog.push_back(1);

         // next cycle
         nv   = '{0, 0};
         push = md_issue && !s_wait;
         popv = 0;
         if (s_rdv) begin
            if (md_pend.size() > 0) begin
               id = md_pend.pop_front();
               nv[id] = 1; md_data = s_rdata; popv = 1;
            end else begin
               md_err = 1;
            end
         end
         if (push && popv) pushpop_cnt++;
         if (push) begin
            md_pend.push_back(md_id);
            md_issue = 0;
         end
         if (win0 || win1) begin
            md_issue = 1;
            md_id    = win1 ? 1 : 0;
            md_addr  = m_addr[md_id];
            md_last  = md_id;
         end
         md_vld = nv;
      end
   end

   // ---------------- stimulus ------------------------------------------------
   bit            acc [2];
   bit            sacc;
   logic [AW-1:0] sacc_addr;
   logic [AW-1:0] sd_q[$];
   int            n_sacc = 0;
   bit            rq_auto = 0, rq_hold = 0, rq_drop = 0;
   int            req_pct = 50;
   bit            sd_manual = 1, sd_resp_en = 0;
   int            stall_pct = 0, resp_pct = 0;

   function automatic logic [DW-1:0] sd_data(input logic [AW-1:0] a);
      if (a == 32'h0000_1000) return 32'hDEADBEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic step();
      @(negedge clk);
      acc[0]    = m_read[0] && !m0_bus.waitrequest;
      acc[1]    = m_read[1] && !m1_bus.waitrequest;
      sacc      = s_bus.read && !s_wait;
      sacc_addr = s_bus.address;
      @(posedge clk);
      #1;
      if (sacc) begin
         sd_q.push_back(sacc_addr);
         n_sacc++;
      end
      if (rq_auto) begin
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               m_read[i] = rq_hold || ($urandom_range(3) == 0);
               m_addr[i] = $urandom & 32'hFFFF_FFFC;
            end else if (!m_read[i]) begin
               if ($urandom_range(99) < req_pct) begin
                  m_read[i] = 1;
                  m_addr[i] = $urandom & 32'hFFFF_FFFC;
               end
            end else if (rq_drop && $urandom_range(15) == 0) begin
               m_read[i] = 0;
            end
         end
      end
      if (!sd_manual) begin
         s_wait = ($urandom_range(99) < stall_pct);
         if (sd_resp_en && sd_q.size() > 0 && $urandom_range(99) < resp_pct) begin
            s_rdv   = 1;
            s_rdata = sd_data(sd_q.pop_front());
         end else begin
            s_rdv   = 0;
            s_rdata = $urandom;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 0;
      m_read = '{0, 0};
      s_rdv = 0; s_wait = 0;
      repeat (2) @(posedge clk);
      #1;
      sd_q.delete();
      rst_n = 1;
      glog.delete(); rlog.delete();
      n_sacc = 0;
   endtask

   initial begin : main_blk
      bit ok;
      m_read = '{0, 0}; m_addr = '{32'h0, 32'h0};
      s_wait = 0; s_rdv = 0; s_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;

      // ---- single read ----
      sd_manual = 1; s_wait = 0;
      m_read[0] = 1; m_addr[0] = 32'h0000_1000;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin step(); ok = acc[0]; end
      chk("t1_accept", ok, 1);
      m_read[0] = 0;
      @(negedge clk);
      chk("t1_s_read", s_bus.read, 1);
      chk("t1_s_addr", s_bus.address, 32'h0000_1000);
      repeat (2) begin @(posedge clk); #1; end
      s_rdv = 1; s_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      s_rdv = 0; s_rdata = '0;
      @(negedge clk);
      chk("t1_m0_rdv", m0_bus.readdatavalid, 1);
      chk("t1_m0_data", m0_bus.readdata, 32'hDEADBEEF);
      chk("t1_m1_rdv", m1_bus.readdatavalid, 0);
      @(posedge clk); #1;
      chk("t1_rsp_count", rlog.size(), 1);

      // ---- tie round-robin ----
      do_reset();
      sd_manual = 0; stall_pct = 0; sd_resp_en = 1; resp_pct = 50;
      rq_auto = 1; rq_hold = 1; rq_drop = 0;
      m_read = '{1, 1}; m_addr = '{32'h100, 32'h200};
      for (int k = 0; k < 100 && glog.size() < 6; k++) step();
      chk("t2_grant_count", glog.size() >= 6, 1);
      for (int i = 0; i < 6 && i < glog.size(); i++)
         chk($sformatf("t2_order%0d", i), glog[i], i % 2);
      rq_auto = 0; rq_hold = 0; m_read = '{0, 0};

      // ---- backpressure ----
      do_reset();
      sd_manual = 1; s_wait = 1; s_rdv = 0;
      m_read[0] = 1; m_addr[0] = 32'h0000_2000;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin step(); ok = acc[0]; end
      chk("t3_accept", ok, 1);
      m_read[0] = 0; m_read[1] = 1; m_addr[1] = 32'h0000_3000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("t3_s_read%0d", c), s_bus.read, 1);
         chk($sformatf("t3_s_addr%0d", c), s_bus.address, 32'h0000_2000);
         chk($sformatf("t3_wait0_%0d", c), m0_bus.waitrequest, 1);
         chk($sformatf("t3_wait1_%0d", c), m1_bus.waitrequest, 1);
         @(posedge clk); #1;
      end
      s_wait = 0;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin step(); ok = acc[1]; end
      chk("t3_m1_accept", ok, 1);
      m_read[1] = 0;

      // ---- pending limit ----
      do_reset();
      sd_manual = 0; stall_pct = 0; sd_resp_en = 0;
      rq_auto = 1; rq_hold = 1; rq_drop = 0;
      m_read = '{1, 1}; m_addr = '{32'h400, 32'h800};
      repeat (30) step();
      chk("t4_issued", n_sacc, MP);
      chk("t4_grants", glog.size(), MP);
      chk("t4_busy", busy, 1);
      chk("t4_held0", m0_bus.waitrequest, 1);
      rlog.delete();
      sd_resp_en = 1; resp_pct = 100;
      for (int k = 0; k < 60 && rlog.size() < 4; k++) step();
      chk("t4_rsp_count", rlog.size() >= 4, 1);
      for (int i = 0; i < 4 && i < rlog.size(); i++)
         chk($sformatf("t4_route%0d", i), rlog[i], i % 2);
      rq_auto = 0; rq_hold = 0; m_read = '{0, 0};
      for (int k = 0; k < 100 && busy; k++) step();
      chk("t4_drained", busy, 0);

      // ---- randomized mix ----
      do_reset();
      pushpop_cnt = 0;
      rq_auto = 1; rq_hold = 0; rq_drop = 1; req_pct = 40;
      sd_manual = 0; stall_pct = 30; sd_resp_en = 1; resp_pct = 45;
      repeat (800) step();
      rq_auto = 0; m_read = '{0, 0}; stall_pct = 0; resp_pct = 100;
      for (int k = 0; k < 200 && (busy || sd_q.size() > 0); k++) step();
      chk("t5_drained", busy, 0);
      chk("t5_reads", rlog.size() >= 20, 1);
      chk("t5_pushpop_seen", pushpop_cnt > 0, 1);

      // ---- reset mid-flight ----
      do_reset();
      sd_manual = 1; s_wait = 0; s_rdv = 0;
      rq_auto = 1; rq_hold = 1; rq_drop = 0;
      m_read = '{1, 1}; m_addr = '{32'hA00, 32'hB00};
      for (int k = 0; k < 40 && n_sacc < 3; k++) step();
      rq_auto = 0; rq_hold = 0; m_read = '{0, 0};
      chk("t6_issued", n_sacc, 3);
      chk("t6_busy_before", busy, 1);
      rst_n = 0;
      @(negedge clk);
      chk("t6_rst_s_read", s_bus.read, 0);
      chk("t6_rst_busy", busy, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1;
      s_rdv = 1; s_rdata = 32'h0000_CAFE;
      @(posedge clk); #1;
      s_rdv = 0;
      @(negedge clk);
      chk("t6_err_orphan", err_orphan, 1);
      chk("t6_m0_rdv", m0_bus.readdatavalid, 0);
      chk("t6_m1_rdv", m1_bus.readdatavalid, 0);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
